// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl
//
// Bridges a blocking cache-side request port to a single memory port.
// Writes are acknowledged as soon as they enter a circular write buffer and
// are drained to memory in the background. A read waits until the buffer is
// empty and no drain transfer is outstanding, so a read never passes a
// buffered write.
//
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   ram_avalid/ram_wr/ram_addr/     cache request, held until ram_ack
//   ram_wdata
//   ram_ack, ram_rdata              one-cycle completion pulse, read data
//   fifo_full, fifo_empty           write-buffer occupancy flags
//   mem_req/mem_we/mem_addr/        memory request, held stable until
//   mem_wdata                       the mem_ready edge
//   mem_rdata, mem_ready            memory read data / transfer complete
//
// Front-end states
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for a cache request
//   RD_WAIT | read pending; waiting for the write buffer to drain
//   RD_MEM  | read issued on the memory port; waiting for mem_ready
//   ACK     | ram_ack pulse for the completed request

module ram_port_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ram_avalid,
    input  logic              ram_wr,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_wdata,
    output logic              ram_ack,
    output logic [DATA_W-1:0] ram_rdata,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_MEM  = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] buf_addr [DEPTH];
    logic [DATA_W-1:0] buf_data [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;

    // A full buffer refuses the write even if the head pops this same edge;
    // the cache simply retries on the next cycle.
    assign push = (state == IDLE) && ram_avalid && ram_wr && (count != FULL_CNT);
    assign pop  = mem_req && mem_we && mem_ready;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);

    // Buffer storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= ram_addr;
            buf_data[wr_ptr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ram_ack   <= 1'b0;
            ram_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            ram_ack <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Memory port: a transfer stays up until mem_ready, then the port
            // idles for one cycle before the next head is issued. The head
            // entry stays in the buffer (and counted) until its drain completes.
            if (mem_req) begin
                if (mem_ready) begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            end else if ((count != '0) && (state != RD_MEM)) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= buf_addr[rd_ptr];
                mem_wdata <= buf_data[rd_ptr];
            end

            // The read is only launched when count is zero and the port is
            // idle, so it never collides with the drain issue above.
            case (state)
                IDLE: begin
                    if (ram_avalid) begin
                        if (ram_wr) begin
                            if (push) begin
                                state   <= ACK;
                                ram_ack <= 1'b1;
                            end
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if ((count == '0) && !mem_req) begin
                        state    <= RD_MEM;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= ram_addr;
                    end
                end
                RD_MEM: begin
                    if (mem_ready) begin
                        ram_rdata <= mem_rdata;
                        state     <= ACK;
                        ram_ack   <= 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Testbench for ram_port_ctrl: cache-side driver, behavioural memory with
// programmable latency/hold, write/read scoreboards and an occupancy model.

module tb_ram_port_ctrl;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ram_avalid;
    logic          ram_wr;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_ack;
    logic [DW-1:0] ram_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    ram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .ram_avalid (ram_avalid),
        .ram_wr     (ram_wr),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_ack    (ram_ack),
        .ram_rdata  (ram_rdata),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t exp_wr[$];
    ent_t exp_rd[$];
    logic [DW-1:0] ref_mem   [logic [AW-1:0]];
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    bit   mem_hold  = 1'b0;
    int   mem_lat   = 0;
    bit   pop_flag  = 1'b0;
    int   cnt_model = 0;
    int   cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_default(input logic [AW-1:0] a);
        return {16'hC0DE, a};
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    // Cache-side request; called just after a falling edge. hold keeps
    // ram_avalid up through the edge that leaves ACK.
    task automatic cache_op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int budget, input bit hold, output int n);
        ent_t e;
        bit   got = 1'b0;
        ram_avalid = 1'b1;
        ram_wr     = wr;
        ram_addr   = a;
        ram_wdata  = d;
        if (wr) begin
            exp_wr.push_back('{a: a, d: d});
            ref_mem[a] = d;
        end else begin
            exp_rd.push_back('{a: a, d: ref_read(a)});
        end
        n = 0;
        while (n < budget && !got) begin
            @(negedge clk);
            n++;
            if (ram_ack) got = 1'b1;
        end
        chk(wr ? "wr_ack_seen" : "rd_ack_seen", 64'(got), 64'd1);
        if (!wr && exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            if (got) chk("rd_data", 64'(ram_rdata), 64'(e.d));
        end
        if (got && hold) begin
            @(negedge clk);
            chk("ack_single", 64'(ram_ack), 64'd0);
        end
        ram_avalid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = fifo_empty && !mem_req;
        end
        chk("drain_done", 64'(ok), 64'd1);
    endtask

    // Memory model: decides mem_ready on the falling edge; the transfer
    // completes on the following rising edge.
    initial begin : mem_side
        int          wait_cnt;
        bit          have_prev;
        logic [63:0] prev_req;
        ent_t        e;
        wait_cnt  = 0;
        have_prev = 1'b0;
        prev_req  = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (reset || !mem_req) begin
                wait_cnt  = 0;
                have_prev = 1'b0;
            end else begin
                if (have_prev) chk("req_stable", 64'({mem_we, mem_addr, mem_wdata}), prev_req);
                prev_req  = 64'({mem_we, mem_addr, mem_wdata});
                have_prev = 1'b1;
                if (!mem_hold && wait_cnt >= mem_lat) begin
                    mem_ready = 1'b1;
                    wait_cnt  = 0;
                    have_prev = 1'b0;
                    if (mem_we) begin
                        if (exp_wr.size() == 0) begin
                            chk("wr_extra", 64'(exp_wr.size()), 64'd1);
                        end else begin
                            e = exp_wr.pop_front();
                            chk("wr_addr", 64'(mem_addr), 64'(e.a));
                            chk("wr_data", 64'(mem_wdata), 64'(e.d));
                        end
                        mem_model[mem_addr] = mem_wdata;
                        pop_flag = 1'b1;
                    end else begin
                        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr]
                                                               : mem_default(mem_addr);
                        chk("rd_after_drain", 64'(fifo_empty), 64'd1);
                        if (exp_rd.size() > 0) chk("rd_addr", 64'(mem_addr), 64'(exp_rd[0].a));
                    end
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Occupancy model: +1 per write ack, -1 per completed drain.
    initial begin : occupancy
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                cnt_model = 0;
                pop_flag  = 1'b0;
            end else begin
                if (ram_ack && ram_wr) cnt_model++;
                if (pop_flag) cnt_model--;
                pop_flag = 1'b0;
                chk("fifo_empty", 64'(fifo_empty), 64'(cnt_model == 0));
                chk("fifo_full", 64'(fifo_full), 64'(cnt_model == DEPTH));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        reset      = 1'b1;
        ram_avalid = 1'b0;
        ram_wr     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        repeat (2) @(negedge clk);
        chk("rst_ram_ack", 64'(ram_ack), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_ram_rdata", 64'(ram_rdata), 64'd0);
        chk("rst_fifo_empty", 64'(fifo_empty), 64'd1);
        chk("rst_fifo_full", 64'(fifo_full), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single write from idle: ack one cycle after acceptance, then drain.
        cache_op(1'b1, 16'h0010, 32'hDEADBEEF, 20, 1'b0, cyc);
        chk("wr_latency", 64'(cyc), 64'd1);
        @(negedge clk);
        chk("drain_issue", 64'({mem_req, mem_we, mem_addr, mem_wdata}),
            64'({1'b1, 1'b1, 16'h0010, 32'hDEADBEEF}));
        wait_idle(20);

        // Fill the buffer with memory stalled; the fifth write waits for a pop
        // and is not accepted on the pop edge itself.
        mem_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cache_op(1'b1, AW'(16'h0100 + i), DW'(32'hA000_0000 + i), 20, 1'b0, cyc);
        end
        fork
            cache_op(1'b1, 16'h0104, 32'hA000_0004, 40, 1'b0, cyc);
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("full_stall", 64'(fifo_full), 64'd1);
                chk("stall_no_ack", 64'(ram_ack), 64'd0);
                mem_hold = 1'b0;
            end
        join
        chk("stall_latency", 64'(cyc), 64'd8);
        wait_idle(60);

        // Read after write with slow memory: read must see the drained data.
        mem_lat = 3;
        cache_op(1'b1, 16'h0020, 32'h0000_0011, 20, 1'b0, cyc);
        cache_op(1'b0, 16'h0020, '0, 60, 1'b0, cyc);
        cache_op(1'b1, 16'h0021, 32'h0000_0022, 20, 1'b0, cyc);
        chk("rdata_hold", 64'(ram_rdata), 64'h11);
        cache_op(1'b0, 16'h0010, '0, 60, 1'b0, cyc);
        cache_op(1'b0, 16'h0099, '0, 60, 1'b0, cyc);
        wait_idle(40);

        // Back-to-back writes across two pointer wraps with fast memory.
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            mem_lat = i % 2;
            cache_op(1'b1, AW'(16'h0200 + i), DW'($urandom), 20, 1'b0, cyc);
        end
        wait_idle(100);
        chk("wr_pending", 64'(exp_wr.size()), 64'd0);
        cache_op(1'b0, 16'h0203, '0, 60, 1'b0, cyc);

        // Reset mid-transfer with three buffered writes.
        mem_lat  = 0;
        mem_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cache_op(1'b1, AW'(16'h0300 + i), DW'(32'h3300_0000 + i), 20, 1'b0, cyc);
        end
        @(negedge clk);
        chk("pre_rst_req", 64'(mem_req), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_req", 64'(mem_req), 64'd0);
        chk("rst_async_empty", 64'(fifo_empty), 64'd1);
        exp_wr.delete();
        @(negedge clk);
        reset    = 1'b0;
        mem_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_ack", 64'(ram_ack), 64'd0);
            chk("rst_no_req", 64'(mem_req), 64'd0);
        end
        cache_op(1'b1, 16'h0040, 32'h0000_4444, 20, 1'b0, cyc);
        chk("post_rst_wr_latency", 64'(cyc), 64'd1);
        wait_idle(20);
        chk("post_rst_pending", 64'(exp_wr.size()), 64'd0);

        // ram_avalid held through ACK: one push, one ack.
        @(negedge clk);
        cache_op(1'b1, 16'h0050, 32'h0000_5555, 20, 1'b1, cyc);
        wait_idle(20);
        repeat (3) @(negedge clk);
        chk("hold_pending", 64'(exp_wr.size()), 64'd0);
        chk("hold_idle", 64'(mem_req), 64'd0);
        cache_op(1'b0, 16'h0050, '0, 60, 1'b0, cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_ctrl.md
RAM_PORT_CTRL -- requirements
Module: ram_port_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: RAM word address width.
REQ-002 Parameter DATA_W, default 32: RAM word data width.
REQ-003 Parameter DEPTH, default 4: write-buffer entries; power of two, >=2.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ram_avalid  in  1  cache-side request valid; held by the cache until ram_ack.
REQ-007 ram_wr  in  1  cache-side request type: 1 = write, 0 = read.
REQ-008 ram_addr  in  ADDR_W  cache-side request address.
REQ-009 ram_wdata  in  DATA_W  cache-side write data.
REQ-010 ram_ack  out  1  one-cycle request-complete pulse to the cache.
REQ-011 ram_rdata  out  DATA_W  read data; valid while ram_ack=1 after a read.
REQ-012 fifo_full  out  1  write buffer holds DEPTH entries.
REQ-013 fifo_empty  out  1  write buffer holds 0 entries.
REQ-014 mem_req  out  1  memory-side request valid.
REQ-015 mem_we  out  1  memory-side request type: 1 = write.
REQ-016 mem_addr  out  ADDR_W  memory-side address.
REQ-017 mem_wdata  out  DATA_W  memory-side write data.
REQ-018 mem_rdata  in  DATA_W  memory read data; valid with mem_ready on a read.
REQ-019 mem_ready  in  1  memory completes the current mem_req transfer at this clock edge.

Function
REQ-020 The write buffer SHALL be a circular FIFO: write pointer, read pointer and count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-021 Front-end FSM states: IDLE, RD_WAIT, RD_MEM, ACK.
REQ-022 IDLE with ram_avalid=1, ram_wr=1 and count<DEPTH: push {ram_addr,ram_wdata} and go to ACK.
REQ-023 IDLE with ram_avalid=1, ram_wr=1 and count==DEPTH: stay in IDLE with no push, including a cycle in which a pop occurs; retry on the next cycle.
REQ-024 IDLE with ram_avalid=1 and ram_wr=0: go to RD_WAIT.
REQ-025 RD_WAIT: go to RD_MEM once count==0 and no drain transfer is in flight, so a read never passes a buffered write.
REQ-026 RD_MEM: drive mem_req=1, mem_we=0, mem_addr=ram_addr; on mem_ready, register mem_rdata into ram_rdata and go to ACK.
REQ-027 ACK: assert ram_ack=1 for exactly this cycle, then return to IDLE; ram_avalid is ignored while in ACK.
REQ-028 Write-request latency SHALL be acceptance edge plus 1 cycle to ram_ack; read latency SHALL be drain time plus memory time plus 1 cycle.
REQ-029 The drain engine SHALL issue the FIFO head as mem_req=1, mem_we=1, mem_addr/mem_wdata=head whenever count>0 and the FSM is not in RD_MEM.
REQ-030 mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable from assertion until the mem_ready edge; there are no back-to-back drops.
REQ-031 A drain completes on the mem_ready edge: pop the head and decrement count; the next head may be issued the following cycle.
REQ-032 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-033 mem_ready while mem_req=0 SHALL be ignored.
REQ-034 fifo_full and fifo_empty SHALL be combinational decodes of count.
REQ-035 ram_rdata SHALL hold its last read value until the next read completes.

Reset
REQ-036 While reset=1: FSM=IDLE; pointers and count=0; ram_ack, mem_req, mem_we=0; mem_addr, mem_wdata, ram_rdata=0; fifo_empty=1; fifo_full=0.
REQ-037 Reset asserted mid-transfer SHALL drop mem_req immediately and discard all buffered writes and any pending read; no ram_ack follows.

Verification
REQ-038 Cache write A=0x0010, D=0xDEADBEEF with buffer empty -> ram_ack 1 cycle after acceptance; mem write to 0x0010 issued next cycle; fifo_empty=1 after mem_ready.
REQ-039 Five writes with mem_ready held 0 and DEPTH=4 -> four acks; fifo_full=1; fifth write stalls with no ack; one mem_ready -> fifth write accepted and acked.
REQ-040 Write 0x20=0x11 then read 0x20 with memory latency 3 -> read mem_req only after the write's mem_ready; ram_rdata=mem_rdata during ram_ack.
REQ-041 Write accepted on the same edge as a drain pop at count=2 -> count stays 2; pointers wrap correctly across 2*DEPTH writes with data order preserved.
REQ-042 Reset pulse while mem_req=1 and count=3 -> mem_req=0 asynchronously; count=0; no ram_ack; the next write proceeds normally.
REQ-043 ram_avalid held high through ACK -> exactly one push and one ram_ack per request.
